// File: rtl/iy_stream_ctrl.sv
// Sequences one frame of pixels line by line into the [-1 0 1]/2 row kernel and tags its results.
// Latency: a read of pixel k surfaces as a tagged kernel result 2+KERNEL_LAT cycles later.
// Backpressure: ds_row_ready is sampled only between lines; a started line always streams to completion.
module iy_stream_ctrl #(
    parameter int LINE_LEN   = 64,
    parameter int NUM_LINES  = 48,
    parameter int ADDR_W     = 12,
    parameter int PIX_W      = 12,
    parameter int KERNEL_LAT = 1,
    localparam int POS_W     = (LINE_LEN  > 1) ? $clog2(LINE_LEN)  : 1,
    localparam int LINE_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic              ds_row_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [PIX_W-1:0]  kern_pixel,
    output logic              out_valid,
    output logic [POS_W-1:0]  out_pos,
    output logic [LINE_W-1:0] out_line,
    output logic              busy,
    output logic              done
);

    // One read-data register plus one kernel-input register, then the kernel itself.
    localparam int TAG_DEPTH = 2 + KERNEL_LAT;
    localparam int DRAIN_W   = $clog2(TAG_DEPTH + 1);

    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(LINE_LEN - 1);
    localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(NUM_LINES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(TAG_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ROW,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // Position tag travelling alongside the pixel through the kernel.
    typedef struct packed {
        logic              vld;
        logic [POS_W-1:0]  pos;
        logic [LINE_W-1:0] line;
    } tag_t;

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [POS_W-1:0]   pos_q;
    logic [LINE_W-1:0]  line_q;
    logic [DRAIN_W-1:0] drain_q;
    logic               rd_vld_q;
    logic [PIX_W-1:0]   kern_pixel_q;
    tag_t               tag_in;
    tag_t               tag_q [TAG_DEPTH];

    logic pos_last;
    logic line_last;

    assign pos_last  = (pos_q == POS_LAST);
    assign line_last = (line_q == LINE_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: line-granular credit check, fixed drain, one-cycle done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_ROW;
                end
            end
            S_WAIT_ROW: begin
                if (ds_row_ready) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pos_last) begin
                    state_d = line_last ? S_DRAIN : S_WAIT_ROW;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address, position and line counters; address is a running linear counter that wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            pos_q  <= '0;
            line_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q <= frame_base;
                        pos_q  <= '0;
                        line_q <= '0;
                    end
                end
                S_STREAM: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (pos_last) begin
                        pos_q <= '0;
                        if (!line_last) begin
                            line_q <= line_q + LINE_W'(1);
                        end
                    end else begin
                        pos_q <= pos_q + POS_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Drain timer: counts the cycles needed for the last tag to leave the pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_q <= '0;
        end else if (state_q == S_DRAIN) begin
            drain_q <= drain_q + DRAIN_W'(1);
        end else begin
            drain_q <= '0;
        end
    end

    // Pixel path: register returning read data; feed zeros when nothing was read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q     <= 1'b0;
            kern_pixel_q <= '0;
        end else begin
            rd_vld_q     <= rd_en;
            kern_pixel_q <= rd_vld_q ? rd_data : '0;
        end
    end

    // A read at position k completes a full 3-tap window only when k>=2 in the same line.
    always_comb begin
        tag_in = '0;
        if (rd_en && (pos_q >= POS_W'(2))) begin
            tag_in.vld  = 1'b1;
            tag_in.pos  = pos_q - POS_W'(1);
            tag_in.line = line_q;
        end
    end

    // Tag shift pipeline matched to the pixel path plus kernel latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < TAG_DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign rd_en      = (state_q == S_STREAM);
    assign rd_addr    = addr_q;
    assign kern_pixel = kern_pixel_q;
    assign out_valid  = tag_q[TAG_DEPTH-1].vld;
    assign out_pos    = tag_q[TAG_DEPTH-1].pos;
    assign out_line   = tag_q[TAG_DEPTH-1].line;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

    // Border centers must never be flagged as interior results.
    a_no_border: assert property (@(posedge clk) disable iff (reset)
        out_valid |-> (out_pos != '0) && (out_pos != POS_LAST));

    // Reads only happen while a frame is in progress.
    a_rd_busy: assert property (@(posedge clk) disable iff (reset)
        rd_en |-> busy);

endmodule

// File: tb/tb_iy_stream_ctrl.sv
// Directed bench for iy_stream_ctrl with a behavioural frame buffer and row kernel.
// Latency: checks tag/data alignment, drain timing and done pulse placement.
// Backpressure: exercises a held-off downstream row credit between lines.
module tb_iy_stream_ctrl;

    localparam int LINE_LEN   = 8;
    localparam int NUM_LINES  = 3;
    localparam int ADDR_W     = 12;
    localparam int PIX_W      = 12;
    localparam int KERNEL_LAT = 1;
    localparam int NRD        = LINE_LEN * NUM_LINES;
    localparam int NOV        = (LINE_LEN - 2) * NUM_LINES;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] frame_base;
    logic              ds_row_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic [PIX_W-1:0]  kern_pixel;
    logic              out_valid;
    logic [2:0]        out_pos;
    logic [1:0]        out_line;
    logic              busy;
    logic              done;

    iy_stream_ctrl #(
        .LINE_LEN   (LINE_LEN),
        .NUM_LINES  (NUM_LINES),
        .ADDR_W     (ADDR_W),
        .PIX_W      (PIX_W),
        .KERNEL_LAT (KERNEL_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .frame_base   (frame_base),
        .ds_row_ready (ds_row_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .kern_pixel   (kern_pixel),
        .out_valid    (out_valid),
        .out_pos      (out_pos),
        .out_line     (out_line),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic desc     = 1'b0;

    int          rd_cyc_q  [$];
    logic [11:0] rd_addr_q [$];
    int          ov_cyc_q  [$];
    logic [2:0]  ov_pos_q  [$];
    logic [1:0]  ov_line_q [$];
    logic [15:0] ov_res_q  [$];
    int          done_cyc_q[$];
    int          kp_bad    = 0;
    logic [11:0] e1 = '0;
    logic [11:0] e2 = '0;

    logic [11:0] x1, x2;
    logic [15:0] kres;

    function automatic logic [11:0] pix_of(input logic [11:0] a);
        logic [12:0] twice;
        twice = {a, 1'b0};
        return desc ? 12'(13'd4094 - twice) : twice[11:0];
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous frame buffer: data one cycle after the read strobe.
    always @(posedge clk) rd_data <= rd_en ? pix_of(rd_addr) : 12'hABC;

    // Row kernel [-1 0 1]/2 with one cycle of latency, sharing the block reset.
    always @(posedge clk) begin
        if (reset) begin
            x1   <= '0;
            x2   <= '0;
            kres <= '0;
        end else begin
            x1   <= kern_pixel;
            x2   <= x1;
            kres <= {4'b0, kern_pixel >> 1} - {4'b0, x2 >> 1};
        end
    end

    // Monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            e1 = '0;
            e2 = '0;
        end else begin
            if (kern_pixel !== e2) kp_bad++;
            e2 = e1;
            e1 = rd_en ? pix_of(rd_addr) : 12'h000;
            if (rd_en) begin
                rd_cyc_q.push_back(cyc);
                rd_addr_q.push_back(rd_addr);
            end
            if (out_valid) begin
                ov_cyc_q.push_back(cyc);
                ov_pos_q.push_back(out_pos);
                ov_line_q.push_back(out_line);
                ov_res_q.push_back(kres);
            end
            if (done) done_cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rd_cyc_q.delete();
        rd_addr_q.delete();
        ov_cyc_q.delete();
        ov_pos_q.delete();
        ov_line_q.delete();
        ov_res_q.delete();
        done_cyc_q.delete();
        kp_bad = 0;
    endtask

    task automatic launch(input logic [11:0] b);
        frame_base = b;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Returns in the DONE cycle; optionally pulses start while busy.
    task automatic wait_done(input string nm, input logic poke);
        int found = 0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                found = 1;
                break;
            end
            start = poke && busy && (i % 3 == 1);
            tick();
        end
        start = 1'b0;
        chk({nm, ".done_seen"}, found, 1);
    endtask

    task automatic wait_rd(input string nm, input logic [11:0] a);
        int found = 0;
        for (int i = 0; i < 200; i++) begin
            if (rd_en && rd_addr == a) begin
                found = 1;
                break;
            end
            tick();
        end
        chk({nm, ".rd_seen"}, found, 1);
    endtask

    task automatic check_frame(input string nm, input logic [11:0] base,
                               input logic [15:0] kexp, input int gap1);
        int nrd;
        int nov;
        logic [11:0] a;
        nrd = rd_addr_q.size();
        nov = ov_pos_q.size();
        chk({nm, ".reads"}, nrd, NRD);
        for (int i = 0; i < nrd && i < NRD; i++) begin
            a = base + 12'(i);
            chk({nm, ".rd_addr"}, 32'(rd_addr_q[i]), 32'(a));
        end
        if (nrd == NRD) begin
            chk({nm, ".gap01"}, rd_cyc_q[LINE_LEN] - rd_cyc_q[LINE_LEN-1], gap1);
            chk({nm, ".gap12"}, rd_cyc_q[2*LINE_LEN] - rd_cyc_q[2*LINE_LEN-1], 2);
        end
        chk({nm, ".valids"}, nov, NOV);
        for (int i = 0; i < nov && i < NOV; i++) begin
            int ln = i / (LINE_LEN - 2);
            int ps = i % (LINE_LEN - 2) + 1;
            chk({nm, ".out_line"}, 32'(ov_line_q[i]), ln);
            chk({nm, ".out_pos"}, 32'(ov_pos_q[i]), ps);
            chk({nm, ".result"}, 32'(ov_res_q[i]), 32'(kexp));
            if (nrd == NRD)
                chk({nm, ".align"}, ov_cyc_q[i] - rd_cyc_q[ln*LINE_LEN + ps + 1], 3);
        end
        if (nrd == NRD && nov > 0)
            chk({nm, ".first_lat"}, ov_cyc_q[0] - rd_cyc_q[0], 5);
        chk({nm, ".done_cnt"}, done_cyc_q.size(), 1);
        if (done_cyc_q.size() == 1 && nrd == NRD)
            chk({nm, ".done_lat"}, done_cyc_q[0] - rd_cyc_q[NRD-1], 4);
        chk({nm, ".kern_pixel"}, kp_bad, 0);
    endtask

    initial begin
        int rise_cyc;
        reset        = 1'b1;
        start        = 1'b0;
        frame_base   = '0;
        ds_row_ready = 1'b1;
        repeat (3) tick();
        chk("rst.rd_en", 32'(rd_en), 0);
        chk("rst.rd_addr", 32'(rd_addr), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.kern_pixel", 32'(kern_pixel), 0);
        reset = 1'b0;
        tick();

        // Ascending ramp.
        clr();
        launch(12'h000);
        chk("s1.busy_start", 32'(busy), 1);
        wait_done("s1", 1'b0);
        tick();
        check_frame("s1", 12'h000, 16'h0002, 2);
        chk("s1.busy_end", 32'(busy), 0);

        // Descending ramp.
        desc = 1'b1;
        clr();
        launch(12'h000);
        wait_done("s2", 1'b0);
        tick();
        check_frame("s2", 12'h000, 16'hFFFE, 2);
        desc = 1'b0;

        // Downstream credit withheld after line 0.
        clr();
        launch(12'h000);
        wait_rd("s3", 12'h007);
        ds_row_ready = 1'b0;
        begin
            int hold_bad = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (rd_en || !busy) hold_bad++;
            end
            chk("s3.hold", hold_bad, 0);
        end
        ds_row_ready = 1'b1;
        rise_cyc = cyc;
        wait_done("s3", 1'b0);
        tick();
        check_frame("s3", 12'h000, 16'h0002, 11);
        if (rd_cyc_q.size() > LINE_LEN)
            chk("s3.resume", rd_cyc_q[LINE_LEN] - rise_cyc, 1);

        // Address wrap, and start pulses while busy with a different base.
        clr();
        launch(12'hFF0);
        frame_base = 12'h123;
        wait_done("s4", 1'b1);
        tick();
        check_frame("s4", 12'hFF0, 16'h0002, 2);
        chk("s4.busy_end", 32'(busy), 0);

        // Reset in the 4th STREAM cycle of line 1.
        clr();
        launch(12'h000);
        wait_rd("s5", 12'h00B);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s5.rd_en", 32'(rd_en), 0);
        chk("s5.out_valid", 32'(out_valid), 0);
        chk("s5.busy", 32'(busy), 0);
        chk("s5.done", 32'(done), 0);
        clr();
        repeat (8) tick();
        chk("s5.stale_valid", ov_pos_q.size(), 0);
        chk("s5.idle_reads", rd_addr_q.size(), 0);
        clr();
        launch(12'h000);
        wait_done("s5b", 1'b0);
        tick();
        check_frame("s5b", 12'h000, 16'h0002, 2);

        // start during DONE is ignored; start the cycle after begins a new frame.
        clr();
        launch(12'h000);
        wait_done("s6", 1'b0);
        start = 1'b1;
        tick();
        chk("s6.done_start_ignored", 32'(busy), 0);
        tick();
        start = 1'b0;
        chk("s6.restart_busy", 32'(busy), 1);
        clr();
        wait_done("s6b", 1'b0);
        tick();
        check_frame("s6b", 12'h000, 16'h0002, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
